// File: rtl/vco_freq_counter.sv
// Gated edge counter measuring the divided VCO output against the reference clock.
// Define VCO_FREQ_CONT_EN to add the CONT port and back-to-back continuous measurement.
module vco_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              PAD_OUT,
  input  logic              START,
  input  logic              ABORT,
  input  logic [GATE_W-1:0] GATE_LEN,
`ifdef VCO_FREQ_CONT_EN
  input  logic              CONT,
`endif
  output logic [CNT_W-1:0]  COUNT,
  output logic              DONE,
  output logic              BUSY,
  output logic              OVF
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0] GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic               sync_s, prev_r, edge_s, cont_s;
  logic [GATE_W-1:0]  gate_cnt_r;
  logic [CNT_W-1:0]   edge_cnt_r, edge_cnt_nxt_s;
  logic               ovf_int_r, ovf_hit_s;
  logic               accept_s, rearm_s, complete_s, zero_done_s;
  logic [CNT_W-1:0]   count_r;
  logic               done_r, busy_r, ovf_r;

`ifdef VCO_FREQ_CONT_EN
  assign cont_s = CONT;
`else
  assign cont_s = 1'b0;
`endif

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign edge_s = sync_s & ~prev_r;

  // Saturating edge increment; an edge arriving at full scale flags overflow.
  always_comb begin
    edge_cnt_nxt_s = edge_cnt_r;
    ovf_hit_s      = 1'b0;
    if (edge_s) begin
      if (edge_cnt_r == CNT_MAX) begin
        ovf_hit_s = 1'b1;
      end else begin
        edge_cnt_nxt_s = edge_cnt_r + CNT_ONE;
      end
    end else begin
      edge_cnt_nxt_s = edge_cnt_r;
    end
  end

  // Next-state logic and the strobes that steer the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    rearm_s     = 1'b0;
    complete_s  = 1'b0;
    zero_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START && !ABORT) begin
          state_nxt_s = ST_ARM;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (ABORT) begin
          state_nxt_s = ST_IDLE;
        end else if (gate_cnt_r == GATE_ZERO) begin
          state_nxt_s = ST_IDLE;
          zero_done_s = 1'b1;
        end else begin
          state_nxt_s = ST_MEAS;
        end
      end
      ST_MEAS: begin
        if (ABORT) begin
          state_nxt_s = ST_IDLE;
        end else if (gate_cnt_r == GATE_ONE) begin
          complete_s = 1'b1;
          if (cont_s) begin
            state_nxt_s = ST_ARM;
            rearm_s     = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_MEAS;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered BUSY.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // PAD_OUT synchronizer; prev tracks sync so ARM never sees a stale edge.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], PAD_OUT};
      prev_r <= sync_s;
    end
  end

  // Gate down-counter, edge counter and window overflow flag.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      gate_cnt_r <= GATE_ZERO;
      edge_cnt_r <= CNT_ZERO;
      ovf_int_r  <= 1'b0;
    end else if (accept_s || rearm_s) begin
      gate_cnt_r <= GATE_LEN;
      edge_cnt_r <= CNT_ZERO;
      ovf_int_r  <= 1'b0;
    end else if (state_r == ST_MEAS) begin
      gate_cnt_r <= gate_cnt_r - GATE_ONE;
      edge_cnt_r <= edge_cnt_nxt_s;
      ovf_int_r  <= ovf_int_r | ovf_hit_s;
    end else begin
      gate_cnt_r <= gate_cnt_r;
      edge_cnt_r <= edge_cnt_r;
      ovf_int_r  <= ovf_int_r;
    end
  end

  // Result registers: updated only on completion; abort leaves them alone.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      count_r <= CNT_ZERO;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (complete_s) begin
      count_r <= edge_cnt_nxt_s;
      ovf_r   <= ovf_int_r | ovf_hit_s;
      done_r  <= 1'b1;
    end else if (zero_done_s) begin
      count_r <= CNT_ZERO;
      ovf_r   <= 1'b0;
      done_r  <= 1'b1;
    end else if (accept_s) begin
      done_r  <= 1'b0;
    end else begin
      count_r <= count_r;
      ovf_r   <= ovf_r;
      done_r  <= done_r;
    end
  end

  assign COUNT = count_r;
  assign DONE  = done_r;
  assign BUSY  = busy_r;
  assign OVF   = ovf_r;

endmodule

// File: tb/tb_vco_freq_counter.sv
// Directed bench for vco_freq_counter (single-shot build); a 16-bit and an 8-bit
// counter share all stimulus so saturation can be checked alongside normal counts.
module tb_vco_freq_counter;

  logic        CLK;
  logic        RESETB;
  logic        PAD_OUT;
  logic        START;
  logic        ABORT;
  logic [15:0] GATE_LEN;
  logic [15:0] count16;
  logic [7:0]  count8;
  logic        done16, busy16, ovf16;
  logic        done8, busy8, ovf8;

  int total = 0;
  int bad   = 0;
  int pad_half = 4;

  vco_freq_counter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut16 (
    .CLK(CLK), .RESETB(RESETB), .PAD_OUT(PAD_OUT), .START(START), .ABORT(ABORT),
    .GATE_LEN(GATE_LEN), .COUNT(count16), .DONE(done16), .BUSY(busy16), .OVF(ovf16)
  );

  vco_freq_counter #(.CNT_W(8), .GATE_W(16), .SYNC_STAGES(2)) dut8 (
    .CLK(CLK), .RESETB(RESETB), .PAD_OUT(PAD_OUT), .START(START), .ABORT(ABORT),
    .GATE_LEN(GATE_LEN), .COUNT(count8), .DONE(done8), .BUSY(busy8), .OVF(ovf8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PAD_OUT: square wave of period 2*pad_half CLK cycles, changing on falling edges.
  initial begin
    int ph;
    ph = 0;
    PAD_OUT = 1'b0;
    forever begin
      @(negedge CLK);
      ph = ph + 1;
      if (ph >= pad_half) begin
        PAD_OUT = ~PAD_OUT;
        ph = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_pad(input int half);
    pad_half = half;
    repeat (12) @(negedge CLK);
  endtask

  // One full window: checks BUSY at edge n, DONE exactly after edge n+1+g.
  task automatic run_win(input int g, input int e16, input int e8, input int o8, input string tag);
    @(negedge CLK);
    START = 1'b1;
    GATE_LEN = g[15:0];
    @(negedge CLK);
    START = 1'b0;
    GATE_LEN = 16'hFFFF;
    chk({tag, "_busy_n"}, {31'd0, busy16}, 32'd1);
    chk({tag, "_done_clr"}, {31'd0, done16}, 32'd0);
    repeat (g) @(negedge CLK);
    if (g > 0) begin
      chk({tag, "_done_early"}, {31'd0, done16}, 32'd0);
      chk({tag, "_busy_mid"}, {31'd0, busy16}, 32'd1);
    end
    @(negedge CLK);
    chk({tag, "_done16"}, {31'd0, done16}, 32'd1);
    chk({tag, "_busy16"}, {31'd0, busy16}, 32'd0);
    chk({tag, "_count16"}, {16'd0, count16}, e16);
    chk({tag, "_ovf16"}, {31'd0, ovf16}, 32'd0);
    chk({tag, "_done8"}, {31'd0, done8}, 32'd1);
    chk({tag, "_count8"}, {24'd0, count8}, e8);
    chk({tag, "_ovf8"}, {31'd0, ovf8}, o8);
  endtask

  initial begin
    RESETB = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    GATE_LEN = 16'd0;

    // Reset with PAD toggling, then release without START.
    repeat (10) @(negedge CLK);
    chk("rst_count", {16'd0, count16}, 32'd0);
    chk("rst_done", {31'd0, done16}, 32'd0);
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_ovf", {31'd0, ovf16}, 32'd0);
    RESETB = 1'b1;
    repeat (10) @(negedge CLK);
    chk("idle_count", {16'd0, count16}, 32'd0);
    chk("idle_done", {31'd0, done16}, 32'd0);
    chk("idle_busy", {31'd0, busy16}, 32'd0);

    set_pad(4);
    run_win(800, 100, 100, 0, "p8_g800");
    run_win(0, 0, 0, 0, "g0");
    set_pad(1);
    run_win(1000, 500, 255, 1, "p2_g1000");
    set_pad(4);
    run_win(80, 10, 10, 0, "p8_g80");
    run_win(800, 100, 100, 0, "p8_g800b");

    // Abort during MEAS keeps the previous result.
    @(negedge CLK);
    START = 1'b1;
    GATE_LEN = 16'd800;
    @(negedge CLK);
    START = 1'b0;
    repeat (300) @(negedge CLK);
    chk("abort_pre_busy", {31'd0, busy16}, 32'd1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort_busy", {31'd0, busy16}, 32'd0);
    chk("abort_done", {31'd0, done16}, 32'd0);
    chk("abort_count", {16'd0, count16}, 32'd100);

    // START with ABORT in IDLE is ignored.
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    chk("sa_busy", {31'd0, busy16}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("sa_busy_late", {31'd0, busy16}, 32'd0);
    chk("sa_count", {16'd0, count16}, 32'd100);

    // Load a saturated result, then reset mid-window.
    set_pad(1);
    run_win(1000, 500, 255, 1, "p2_again");
    @(negedge CLK);
    START = 1'b1;
    GATE_LEN = 16'd800;
    @(negedge CLK);
    START = 1'b0;
    repeat (200) @(negedge CLK);
    chk("mid_busy", {31'd0, busy8}, 32'd1);
    RESETB = 1'b0;
    #1;
    chk("mrst_count16", {16'd0, count16}, 32'd0);
    chk("mrst_count8", {24'd0, count8}, 32'd0);
    chk("mrst_ovf8", {31'd0, ovf8}, 32'd0);
    chk("mrst_busy", {31'd0, busy16}, 32'd0);
    chk("mrst_done", {31'd0, done8}, 32'd0);
    repeat (3) @(negedge CLK);
    RESETB = 1'b1;
    repeat (5) @(negedge CLK);
    chk("post_busy", {31'd0, busy16}, 32'd0);
    chk("post_done", {31'd0, done16}, 32'd0);
    chk("post_count", {16'd0, count16}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
